// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the sized data memory.
package dm_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } dm_state_e;

  // Reserved size reports 4 so the range check stays conservative; it errors anyway.
  function automatic logic [2:0] size_bytes(input logic [1:0] sz);
    case (sz)
      SZ_BYTE: size_bytes = 3'd1;
      SZ_HALF: size_bytes = 3'd2;
      SZ_WORD: size_bytes = 3'd4;
      default: size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/dm_byte_array.sv
// Byte storage with per-lane write enables and a four-byte little-endian read window.
module dm_byte_array #(
  parameter int DEPTH = 1024,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          CLK,
  input  logic [3:0]    we,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem_q [DEPTH];
  logic [AW:0] lane_addr_d [4];

  // Lane addresses carry an extra bit so lanes past the top are detectable.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      lane_addr_d[i] = {1'b0, addr} + (AW+1)'(i);
    end
  end

  // Little-endian read; lanes beyond the array read as zero.
  always_comb begin
    rdata = 32'h0000_0000;
    for (int i = 0; i < 4; i++) begin
      if (lane_addr_d[i] < (AW+1)'(DEPTH)) begin
        rdata[8*i +: 8] = mem_q[lane_addr_d[i][AW-1:0]];
      end else begin
        rdata[8*i +: 8] = 8'h00;
      end
    end
  end

  // Per-lane byte write.
  always_ff @(posedge CLK) begin
    for (int i = 0; i < 4; i++) begin
      if (we[i] && (lane_addr_d[i] < (AW+1)'(DEPTH))) begin
        mem_q[lane_addr_d[i][AW-1:0]] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/data_mem_sized.sv
// Byte-addressed little-endian data memory with Req/Ready handshake, wait states,
// sized/extended loads and misalignment/range error reporting.
module data_mem_sized
  import dm_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DEPTH_BYTES = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  Req,
  input  logic                  DataMemRW,
  input  logic [1:0]            Size,
  input  logic                  Unsigned,
  input  logic [ADDR_WIDTH-1:0] DAddr,
  input  logic [31:0]           DataIn,
  output logic [31:0]           DataOut,
  output logic                  Ready,
  output logic                  Err
);

  localparam int AW = $clog2(DEPTH_BYTES);

  dm_state_e             state_q;
  logic [3:0]            cnt_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [31:0]           wdata_q;
  logic [1:0]            size_q;
  logic                  uns_q;
  logic                  rw_q;
  logic [31:0]           dout_q;
  logic                  ready_q;
  logic                  err_q;

  logic [ADDR_WIDTH:0]   end_addr_d;
  logic                  access_err_d;
  logic                  commit_d;
  logic [3:0]            lane_we_d;
  logic [31:0]           rdata_d;
  logic [31:0]           load_data_d;
  logic                  ext_d;

  // Error check on the latched request.
  always_comb begin
    end_addr_d   = {1'b0, addr_q} + (ADDR_WIDTH+1)'(size_bytes(size_q)) - (ADDR_WIDTH+1)'(1);
    access_err_d = end_addr_d >= (ADDR_WIDTH+1)'(DEPTH_BYTES);
    case (size_q)
      SZ_BYTE: access_err_d = access_err_d;
      SZ_HALF: access_err_d = access_err_d | addr_q[0];
      SZ_WORD: access_err_d = access_err_d | (|addr_q[1:0]);
      default: access_err_d = 1'b1;
    endcase
  end

  // The array is written only on the BUSY->RESP edge of an error-free store.
  always_comb begin
    commit_d  = (state_q == S_BUSY) && (cnt_q == 4'd0) && !access_err_d;
    lane_we_d = 4'b0000;
    if (commit_d && rw_q) begin
      case (size_q)
        SZ_BYTE: lane_we_d = 4'b0001;
        SZ_HALF: lane_we_d = 4'b0011;
        SZ_WORD: lane_we_d = 4'b1111;
        default: lane_we_d = 4'b0000;
      endcase
    end else begin
      lane_we_d = 4'b0000;
    end
  end

  dm_byte_array #(
    .DEPTH (DEPTH_BYTES),
    .AW    (AW)
  ) u_array (
    .CLK   (CLK),
    .we    (lane_we_d),
    .addr  (addr_q[AW-1:0]),
    .wdata (wdata_q),
    .rdata (rdata_d)
  );

  // Load extension.
  always_comb begin
    ext_d       = 1'b0;
    load_data_d = rdata_d;
    case (size_q)
      SZ_BYTE: begin
        ext_d       = !uns_q && rdata_d[7];
        load_data_d = {{24{ext_d}}, rdata_d[7:0]};
      end
      SZ_HALF: begin
        ext_d       = !uns_q && rdata_d[15];
        load_data_d = {{16{ext_d}}, rdata_d[15:0]};
      end
      default: begin
        ext_d       = 1'b0;
        load_data_d = rdata_d;
      end
    endcase
  end

  // Handshake FSM with wait counter and registered Ready/Err/DataOut.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= '0;
      wdata_q <= 32'h0000_0000;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      rw_q    <= 1'b0;
      dout_q  <= 32'h0000_0000;
      ready_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          if (Req) begin
            addr_q  <= DAddr;
            wdata_q <= DataIn;
            size_q  <= Size;
            uns_q   <= Unsigned;
            rw_q    <= DataMemRW;
            cnt_q   <= 4'(WAIT_CYCLES);
            state_q <= S_BUSY;
          end else begin
            state_q <= S_IDLE;
          end
        end
        S_BUSY: begin
          if (cnt_q == 4'd0) begin
            state_q <= S_RESP;
            ready_q <= 1'b1;
            err_q   <= access_err_d;
            if (commit_d && !rw_q) begin
              dout_q <= load_data_d;
            end else begin
              dout_q <= dout_q;
            end
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        S_RESP: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          ready_q <= 1'b0;
          err_q   <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign DataOut = dout_q;
  assign Ready   = ready_q;
  assign Err     = err_q;

endmodule

// File: tb/tb_data_mem_sized.sv
// Scoreboard bench for data_mem_sized: main instance with one wait state,
// plus zero- and three-wait-state instances for the latency sweep.
module tb_data_mem_sized;
  import dm_pkg::*;

  localparam int DEPTH = 1024;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req1, req0, req3;
  logic        rw;
  logic [1:0]  size;
  logic        uns;
  logic [31:0] addr, din;
  logic [31:0] dout1, dout0, dout3;
  logic        rdy1, rdy0, rdy3;
  logic        err1, err0, err3;

  always #5 clk = ~clk;

  data_mem_sized #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(1)) u_w1 (
    .CLK(clk), .RST(rst_n), .Req(req1), .DataMemRW(rw), .Size(size), .Unsigned(uns),
    .DAddr(addr), .DataIn(din), .DataOut(dout1), .Ready(rdy1), .Err(err1));
  data_mem_sized #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(0)) u_w0 (
    .CLK(clk), .RST(rst_n), .Req(req0), .DataMemRW(rw), .Size(size), .Unsigned(uns),
    .DAddr(addr), .DataIn(din), .DataOut(dout0), .Ready(rdy0), .Err(err0));
  data_mem_sized #(.ADDR_WIDTH(32), .DEPTH_BYTES(DEPTH), .WAIT_CYCLES(3)) u_w3 (
    .CLK(clk), .RST(rst_n), .Req(req3), .DataMemRW(rw), .Size(size), .Unsigned(uns),
    .DAddr(addr), .DataIn(din), .DataOut(dout3), .Ready(rdy3), .Err(err3));

  typedef struct {
    logic        err;
    logic [31:0] dout;
  } exp_t;

  exp_t        sb[$];
  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] last_dout = 32'h0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  // One access on the WAIT_CYCLES=1 instance; rd is the load result if it is a good read.
  task automatic access(input string tag, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d, input logic e,
                        input logic [31:0] rd);
    exp_t x;
    int   lat;
    bit   seen;
    x.err  = e;
    x.dout = (w || e) ? last_dout : rd;
    if (!w && !e) last_dout = rd;
    sb.push_back(x);
    @(negedge clk);
    rw = w; size = sz; uns = u; addr = a; din = d; req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0; addr = ~a; din = ~d; uns = ~u; size = ~sz; rw = ~w;
    seen = 1'b0;
    lat  = 0;
    while (!seen && lat < 20) begin
      @(posedge clk);
      #1;
      lat++;
      if (rdy1) seen = 1'b1;
    end
    x = sb.pop_front();
    check({tag, "_ready"}, 32'(seen), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd2);
    check({tag, "_err"}, 32'(err1), 32'(x.err));
    check({tag, "_dout"}, dout1, x.dout);
    @(posedge clk);
    #1;
    check({tag, "_pulse"}, 32'(rdy1), 32'd0);
  endtask

  // Hold Req high on the WAIT_CYCLES=0 or 3 instance and check Ready cadence.
  task automatic sweep(input int w);
    int  last_idx = -1;
    int  pulses   = 0;
    int  accepts;
    bit  prev_r   = 1'b0;
    bit  r, e;
    @(negedge clk);
    rw = 1'b1; size = SZ_WORD; uns = 1'b0; addr = 32'h40; din = 32'h0BAD_CAFE;
    if (w == 0) req0 = 1'b1; else req3 = 1'b1;
    for (int c = 0; c < 52; c++) begin
      @(posedge clk);
      #1;
      r = (w == 0) ? rdy0 : rdy3;
      e = (w == 0) ? err0 : err3;
      if (r) begin
        check($sformatf("sweep%0d_single", w), 32'(prev_r), 32'd0);
        check($sformatf("sweep%0d_err", w), 32'(e), 32'd0);
        if (last_idx < 0) check($sformatf("sweep%0d_first", w), 32'(c), 32'(w + 1));
        else check($sformatf("sweep%0d_spacing", w), 32'(c - last_idx), 32'(w + 3));
        last_idx = c;
        pulses++;
      end
      prev_r = r;
      if (c == 39) begin
        req0 = 1'b0;
        req3 = 1'b0;
      end
    end
    accepts = 39 / (w + 3) + 1;
    check($sformatf("sweep%0d_count", w), 32'(pulses), 32'(accepts));
  endtask

  initial begin
    int quiet;
    rst_n = 1'b0;
    req1 = 1'b0; req0 = 1'b0; req3 = 1'b0;
    rw = 1'b0; size = SZ_BYTE; uns = 1'b0; addr = 32'h0; din = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_ready", 32'(rdy1), 32'd0);
    check("reset_err", 32'(err1), 32'd0);
    check("reset_dout", dout1, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // word write/read
    access("t1_wr", 1'b1, SZ_WORD, 1'b0, 32'h10, 32'h8765_4321, 1'b0, 32'h0);
    access("t1_rd", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8765_4321);
    // byte/half loads with extension
    access("t2_b13s", 1'b0, SZ_BYTE, 1'b0, 32'h13, 32'h0, 1'b0, 32'hFFFF_FF87);
    access("t2_b13u", 1'b0, SZ_BYTE, 1'b1, 32'h13, 32'h0, 1'b0, 32'h0000_0087);
    access("t2_h12s", 1'b0, SZ_HALF, 1'b0, 32'h12, 32'h0, 1'b0, 32'hFFFF_8765);
    access("t2_h10u", 1'b0, SZ_HALF, 1'b1, 32'h10, 32'h0, 1'b0, 32'h0000_4321);
    access("t2_b10s", 1'b0, SZ_BYTE, 1'b0, 32'h10, 32'h0, 1'b0, 32'h0000_0021);
    // partial write
    access("t3_wb", 1'b1, SZ_BYTE, 1'b0, 32'h11, 32'hFFFF_FFAA, 1'b0, 32'h0);
    access("t3_rd", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8765_AA21);
    // errors
    access("t4_wmis", 1'b1, SZ_WORD, 1'b0, 32'h12, 32'h1234_5678, 1'b1, 32'h0);
    access("t4_hmis", 1'b1, SZ_HALF, 1'b0, 32'h11, 32'h0000_5555, 1'b1, 32'h0);
    access("t4_reread", 1'b0, SZ_WORD, 1'b0, 32'h10, 32'h0, 1'b0, 32'h8765_AA21);
    access("t4_oor", 1'b0, SZ_WORD, 1'b0, DEPTH - 2, 32'h0, 1'b1, 32'h0);
    access("t4_rsvd", 1'b0, SZ_RSVD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0);
    access("t4_wtop", 1'b1, SZ_WORD, 1'b0, DEPTH, 32'hFFFF_FFFF, 1'b1, 32'h0);
    access("t4_btopw", 1'b1, SZ_BYTE, 1'b0, DEPTH - 1, 32'h0000_005A, 1'b0, 32'h0);
    access("t4_btopr", 1'b0, SZ_BYTE, 1'b1, DEPTH - 1, 32'h0, 1'b0, 32'h0000_005A);
    access("t4_htop", 1'b0, SZ_HALF, 1'b0, DEPTH - 1, 32'h0, 1'b1, 32'h0);

    // reset during BUSY aborts the write
    access("t5_pre", 1'b1, SZ_WORD, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 32'h0);
    @(negedge clk);
    rw = 1'b1; size = SZ_WORD; uns = 1'b0; addr = 32'h20; din = 32'hDEAD_BEEF; req1 = 1'b1;
    @(posedge clk);
    #1;
    req1 = 1'b0;
    rst_n = 1'b0;
    #1;
    check("t5_ready", 32'(rdy1), 32'd0);
    check("t5_err", 32'(err1), 32'd0);
    check("t5_dout", dout1, 32'h0);
    last_dout = 32'h0;
    @(negedge clk);
    rst_n = 1'b1;
    quiet = 0;
    repeat (5) begin
      @(posedge clk);
      #1;
      if (rdy1) quiet++;
    end
    check("t5_no_ready", 32'(quiet), 32'd0);
    access("t5_rd", 1'b0, SZ_WORD, 1'b0, 32'h20, 32'h0, 1'b0, 32'h1122_3344);

    // latency sweep
    sweep(0);
    sweep(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
